// File: rtl/accumulator_pipe_nbit.sv
// Two-stage pipelined N-bit accumulator: ADD/SUB/LOAD/CLEAR with carry, overflow, sticky flag and op counter.
// Optional build macro ACC_SATURATE_EN clamps o_S on a flagged overflow instead of wrapping.
module accumulator_pipe_nbit #(
  parameter int N      = 8,
  parameter int SIGNED = 0,
  parameter int CW     = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [1:0]    i_op,
  input  logic [N-1:0]  i_A,
  input  logic          i_clr_flags,
  output logic [N-1:0]  o_S,
  output logic          o_carry,
  output logic          o_ovf,
  output logic          o_sticky_ovf,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic          s1_valid_r;
  logic [1:0]    s1_op_r;
  logic [N-1:0]  s1_a_r;

  logic [N:0]    sum_s;
  logic [N:0]    diff_s;
  logic [N-1:0]  next_s_s;
  logic [N-1:0]  res_s;
  logic          carry_s;
  logic          ovf_s;
  logic          flag_s;

  // Stage 1: capture operand and opcode when presented
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 2'b00;
      s1_a_r     <= {N{1'b0}};
    end else begin
      s1_valid_r <= i_valid;
      if (i_valid) begin
        s1_op_r <= i_op;
        s1_a_r  <= i_A;
      end else begin
        s1_op_r <= s1_op_r;
        s1_a_r  <= s1_a_r;
      end
    end
  end

  assign sum_s  = {1'b0, o_S} + {1'b0, s1_a_r};
  assign diff_s = {1'b0, o_S} - {1'b0, s1_a_r};

  // Stage 2 arithmetic: wrapped result plus carry/borrow and signed overflow
  always_comb begin
    next_s_s = o_S;
    carry_s  = 1'b0;
    ovf_s    = 1'b0;
    case (s1_op_r)
      OP_ADD: begin
        next_s_s = sum_s[N-1:0];
        carry_s  = sum_s[N];
        ovf_s    = (o_S[N-1] == s1_a_r[N-1]) && (sum_s[N-1] != o_S[N-1]);
      end
      OP_SUB: begin
        next_s_s = diff_s[N-1:0];
        carry_s  = diff_s[N];
        ovf_s    = (o_S[N-1] != s1_a_r[N-1]) && (diff_s[N-1] != o_S[N-1]);
      end
      OP_LOAD: begin
        next_s_s = s1_a_r;
      end
      OP_CLEAR: begin
        next_s_s = {N{1'b0}};
      end
      default: begin
        next_s_s = o_S;
      end
    endcase
  end

  assign flag_s = (SIGNED != 0) ? ovf_s : carry_s;

`ifdef ACC_SATURATE_EN
  // Clamp on flagged overflow; a signed overflow's direction follows the sign of the old accumulator
  always_comb begin
    res_s = next_s_s;
    if (flag_s) begin
      if (SIGNED == 0) begin
        if (s1_op_r == OP_ADD) begin
          res_s = {N{1'b1}};
        end else begin
          res_s = {N{1'b0}};
        end
      end else begin
        if (o_S[N-1]) begin
          res_s = {1'b1, {(N-1){1'b0}}};
        end else begin
          res_s = {1'b0, {(N-1){1'b1}}};
        end
      end
    end else begin
      res_s = next_s_s;
    end
  end
`else
  assign res_s = next_s_s;
`endif

  // Stage 2 registers: result, flags, valid pulse and counter; sticky set wins over clear
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_S          <= {N{1'b0}};
      o_carry      <= 1'b0;
      o_ovf        <= 1'b0;
      o_sticky_ovf <= 1'b0;
      o_valid      <= 1'b0;
      o_count      <= {CW{1'b0}};
    end else begin
      o_valid <= s1_valid_r;
      if (s1_valid_r) begin
        o_S     <= res_s;
        o_carry <= carry_s;
        o_ovf   <= ovf_s;
        o_count <= o_count + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        o_S     <= o_S;
        o_carry <= o_carry;
        o_ovf   <= o_ovf;
        o_count <= o_count;
      end
      if (s1_valid_r && flag_s) begin
        o_sticky_ovf <= 1'b1;
      end else if (i_clr_flags) begin
        o_sticky_ovf <= 1'b0;
      end else begin
        o_sticky_ovf <= o_sticky_ovf;
      end
    end
  end

endmodule

// File: tb/tb_accumulator_pipe_nbit.sv
// Bench for accumulator_pipe_nbit: an unsigned CW=2 instance and a signed CW=8 instance share stimulus,
// with a queue of expected results pushed at drive time and popped when the result is due.
module tb_accumulator_pipe_nbit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] a = 8'h00;
  logic       clr = 1'b0;

  logic [7:0] u_s, s_s;
  logic       u_c, u_v, u_st, u_vl, s_c, s_v, s_st, s_vl;
  logic [1:0] u_k;
  logic [7:0] s_k;

  always #5 clk = ~clk;

  accumulator_pipe_nbit #(.N(8), .SIGNED(0), .CW(2)) dut_u (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_op(op), .i_A(a), .i_clr_flags(clr),
    .o_S(u_s), .o_carry(u_c), .o_ovf(u_v), .o_sticky_ovf(u_st), .o_valid(u_vl), .o_count(u_k));

  accumulator_pipe_nbit #(.N(8), .SIGNED(1), .CW(8)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_op(op), .i_A(a), .i_clr_flags(clr),
    .o_S(s_s), .o_carry(s_c), .o_ovf(s_v), .o_sticky_ovf(s_st), .o_valid(s_vl), .o_count(s_k));

  typedef struct packed {
    logic [7:0] su; logic cu; logic vu; logic fu; logic [1:0] ku;
    logic [7:0] ss; logic cs; logic vs; logic fs; logic [7:0] ks;
    int due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  // model state at push time (chains ops) and expected visible outputs
  logic [7:0] mu_s = 8'h00, ms_s = 8'h00;
  logic [1:0] mu_k = 2'd0;
  logic [7:0] ms_k = 8'h00;
  logic [7:0] eu_s = 8'h00, es_s = 8'h00;
  logic       eu_c = 1'b0, eu_v = 1'b0, es_c = 1'b0, es_v = 1'b0;
  logic [1:0] eu_k = 2'd0;
  logic [7:0] es_k = 8'h00;
  logic       eu_st = 1'b0, es_st = 1'b0, e_vl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
  endtask

  // reference arithmetic written with plain integers
  task automatic model(input logic [1:0] o, input logic [7:0] s, input logic [7:0] x, input bit sgn,
                       output logic [7:0] r, output logic c, output logic v, output logic f);
    int ures, sres;
    ures = 0; sres = 0; c = 1'b0; v = 1'b0; r = s;
    case (o)
      2'b00: begin
        ures = int'(s) + int'(x);
        sres = int'($signed(s)) + int'($signed(x));
        c = (ures > 255); v = (sres > 127) || (sres < -128); r = ures[7:0];
      end
      2'b01: begin
        ures = int'(s) - int'(x);
        sres = int'($signed(s)) - int'($signed(x));
        c = (int'(x) > int'(s)); v = (sres > 127) || (sres < -128); r = ures[7:0];
      end
      2'b10: r = x;
      default: r = 8'h00;
    endcase
    f = sgn ? v : c;
`ifdef ACC_SATURATE_EN
    if (f) begin
      if (!sgn) r = (o == 2'b00) ? 8'hFF : 8'h00;
      else r = (sres > 127) ? 8'h7F : 8'h80;
    end
`endif
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".u_S"}, 32'(u_s), 32'(eu_s));
    chk({tag, ".u_carry"}, 32'(u_c), 32'(eu_c));
    chk({tag, ".u_ovf"}, 32'(u_v), 32'(eu_v));
    chk({tag, ".u_sticky"}, 32'(u_st), 32'(eu_st));
    chk({tag, ".u_valid"}, 32'(u_vl), 32'(e_vl));
    chk({tag, ".u_count"}, 32'(u_k), 32'(eu_k));
    chk({tag, ".s_S"}, 32'(s_s), 32'(es_s));
    chk({tag, ".s_carry"}, 32'(s_c), 32'(es_c));
    chk({tag, ".s_ovf"}, 32'(s_v), 32'(es_v));
    chk({tag, ".s_sticky"}, 32'(s_st), 32'(es_st));
    chk({tag, ".s_valid"}, 32'(s_vl), 32'(e_vl));
    chk({tag, ".s_count"}, 32'(s_k), 32'(es_k));
  endtask

  // drive one cycle of inputs, advance one edge, then compare against the scoreboard
  task automatic step(input string tag, input logic v, input logic [1:0] o, input logic [7:0] x, input logic c);
    exp_t e;
    @(negedge clk);
    valid = v; op = o; a = x; clr = c;
    if (v) begin
      model(o, mu_s, x, 1'b0, e.su, e.cu, e.vu, e.fu);
      model(o, ms_s, x, 1'b1, e.ss, e.cs, e.vs, e.fs);
      mu_s = e.su; ms_s = e.ss;
      mu_k = mu_k + 2'd1; ms_k = ms_k + 8'd1;
      e.ku = mu_k; e.ks = ms_k; e.due = cyc + 2;
      q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      e_vl = 1'b1;
      eu_s = e.su; eu_c = e.cu; eu_v = e.vu; eu_k = e.ku; eu_st = e.fu | (eu_st & ~c);
      es_s = e.ss; es_c = e.cs; es_v = e.vs; es_k = e.ks; es_st = e.fs | (es_st & ~c);
    end else begin
      e_vl = 1'b0;
      eu_st = eu_st & ~c;
      es_st = es_st & ~c;
    end
    check_outputs(tag);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst = 1'b0; valid = 1'b0; clr = 1'b0;
    #1;
    q.delete();
    mu_s = 8'h00; ms_s = 8'h00; mu_k = 2'd0; ms_k = 8'h00;
    eu_s = 8'h00; es_s = 8'h00; eu_c = 1'b0; eu_v = 1'b0; es_c = 1'b0; es_v = 1'b0;
    eu_k = 2'd0; es_k = 8'h00; eu_st = 1'b0; es_st = 1'b0; e_vl = 1'b0;
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    apply_reset("reset0");
    step("idle0", 1'b0, 2'b00, 8'h00, 1'b0);
    // reset mid-stream with an op in flight
    step("ld55", 1'b1, 2'b10, 8'h55, 1'b0);
    step("ld55r", 1'b1, 2'b00, 8'h02, 1'b0);
    apply_reset("reset_mid");
    step("add1", 1'b1, 2'b00, 8'h01, 1'b0);
    step("add1r", 1'b0, 2'b00, 8'h00, 1'b0);
    chk("after_reset_S", 32'(u_s), 32'h01);
    // back-to-back chaining
    step("ld10", 1'b1, 2'b10, 8'h10, 1'b0);
    step("add05", 1'b1, 2'b00, 8'h05, 1'b0);
    step("sub03", 1'b1, 2'b01, 8'h03, 1'b0);
    step("chain_r2", 1'b0, 2'b00, 8'h00, 1'b0);
    chk("chain_S", 32'(u_s), 32'h12);
    step("chain_idle", 1'b0, 2'b00, 8'h00, 1'b0);
    // unsigned carry and borrow
    step("ldF0", 1'b1, 2'b10, 8'hF0, 1'b0);
    step("add20", 1'b1, 2'b00, 8'h20, 1'b0);
    step("sub20", 1'b1, 2'b01, 8'h20, 1'b0);
    step("cb_r2", 1'b0, 2'b00, 8'h00, 1'b0);
    step("cb_idle", 1'b0, 2'b00, 8'h00, 1'b1);
    // signed overflow
    step("ld7F", 1'b1, 2'b10, 8'h7F, 1'b0);
    step("add01", 1'b1, 2'b00, 8'h01, 1'b0);
    step("sov_r", 1'b0, 2'b00, 8'h00, 1'b0);
    // sticky set/clear race, then clear alone
    step("ld7F_b", 1'b1, 2'b10, 8'h7F, 1'b1);
    step("add01_b", 1'b1, 2'b00, 8'h01, 1'b0);
    step("race", 1'b0, 2'b00, 8'h00, 1'b1);
    step("clr_alone", 1'b0, 2'b00, 8'h00, 1'b1);
    step("ldF0_b", 1'b1, 2'b10, 8'hF0, 1'b0);
    step("addF0", 1'b1, 2'b00, 8'hF0, 1'b0);
    step("race_u", 1'b0, 2'b00, 8'h00, 1'b1);
    step("clr_u", 1'b0, 2'b00, 8'h00, 1'b1);
    // counter wrap through CLEAR ops
    for (int i = 0; i < 5; i++) step("clear", 1'b1, 2'b11, 8'hA5, 1'b0);
    step("clear_r", 1'b0, 2'b00, 8'h00, 1'b0);
    // random mix
    for (int i = 0; i < 40; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 3) == 0));
    step("tail", 1'b0, 2'b00, 8'h00, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
